// File: rtl/trap_ctrl_pkg.sv
// ============================================================================
// Module  : trap_ctrl_pkg
// Purpose : Shared constants for the trap/return sequencer: FSM state
//           encodings, machine-mode CSR addresses and mstatus bit positions.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package trap_ctrl_pkg;

  // FSM state encodings. ST_W_MTVAL is only reachable when TRAP_MTVAL_EN is
  // defined in the build.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_W_MEPC    = 3'd1;
  localparam logic [2:0] ST_W_MCAUSE  = 3'd2;
  localparam logic [2:0] ST_W_MTVAL   = 3'd3;
  localparam logic [2:0] ST_W_MSTATUS = 3'd4;
  localparam logic [2:0] ST_M_STATUS  = 3'd5;
  localparam logic [2:0] ST_REDIRECT  = 3'd6;

  // Machine-mode CSR addresses.
  localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] CSR_MTVEC   = 32'h0000_0305;
  localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;
  localparam logic [31:0] CSR_MTVAL   = 32'h0000_0343;

  // mstatus bit positions.
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

endpackage

`default_nettype wire

// File: rtl/trap_ctrl_mstatus_next.sv
// ============================================================================
// Module  : mstatus_next
// Purpose : Combinational mstatus update for trap entry and MRET.
// Ports   : mstatus_i  current mstatus
//           ret_i      0 = trap entry, 1 = MRET
//           mstatus_o  updated mstatus
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mstatus_next
  import trap_ctrl_pkg::*;
(
  input  logic [31:0] mstatus_i,
  input  logic        ret_i,
  output logic [31:0] mstatus_o
);

  always_comb begin
    mstatus_o = mstatus_i;
    // The only privilege level implemented is M, so MPP is always 2'b11.
    mstatus_o[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    if (ret_i) begin
      mstatus_o[MSTATUS_MIE]  = mstatus_i[MSTATUS_MPIE];
      mstatus_o[MSTATUS_MPIE] = 1'b1;
    end else begin
      mstatus_o[MSTATUS_MPIE] = mstatus_i[MSTATUS_MIE];
      mstatus_o[MSTATUS_MIE]  = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/trap_ctrl.sv
// ============================================================================
// Module  : trap_ctrl
// Purpose : Multi-cycle trap-entry / MRET sequencer. Owns the single CSR
//           write port, arbitrating between decode CSR writes and the
//           trap/return write sequence, stalls fetch while sequencing and
//           issues a one-cycle PC redirect to mtvec or mepc.
// Ports   : trap_req/cause/pc/tval  trap request from decode
//           mret_req                MRET request from decode
//           dec_csr_*               ordinary decode CSR write
//           mstatus/mtvec/mepc      current CSR values
//           csr_we/waddr/wdata      CSR file write port
//           stall, busy             pipeline hold / FSM not idle
//           redirect_valid/pc       one-cycle PC redirect
// Config  : TRAP_MTVAL_EN - when defined, an mtval write state is added and
//           trap_tval is captured; otherwise trap_tval is ignored.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_req,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  input  logic        mret_req,
  input  logic        dec_csr_wb,
  input  logic [31:0] dec_csr_addr,
  input  logic [31:0] dec_csr_wdata,
  input  logic [31:0] mstatus,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        csr_we,
  output logic [31:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        stall,
  output logic        busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  logic [2:0]  state_q, state_d;
  logic        is_mret_q, is_mret_d;   // redirect target: 1 = mepc, 0 = mtvec
  logic [31:0] pc_q, pc_d;
  logic [31:0] cause_q, cause_d;
`ifdef TRAP_MTVAL_EN
  logic [31:0] tval_q, tval_d;
`else
  // trap_tval has no consumer in this build.
  logic unused_tval;
  assign unused_tval = ^trap_tval;
`endif

  // mtvec's low bits hold the vectoring mode; only direct mode is used.
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^mtvec[1:0];

  logic is_idle;
  logic accept;
  logic [31:0] mstatus_upd;

  assign is_idle = (state_q == ST_IDLE);
  assign accept  = is_idle & (trap_req | mret_req);

  mstatus_next u_mstatus_next (
    .mstatus_i (mstatus),
    .ret_i     (state_q == ST_M_STATUS),
    .mstatus_o (mstatus_upd)
  );

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    is_mret_d = is_mret_q;
    pc_d      = pc_q;
    cause_d   = cause_q;
`ifdef TRAP_MTVAL_EN
    tval_d    = tval_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // trap_req wins over mret_req when both are presented.
        if (trap_req) begin
          pc_d      = trap_pc;
          cause_d   = trap_cause;
`ifdef TRAP_MTVAL_EN
          tval_d    = trap_tval;
`endif
          is_mret_d = 1'b0;
          state_d   = ST_W_MEPC;
        end else if (mret_req) begin
          is_mret_d = 1'b1;
          state_d   = ST_M_STATUS;
        end
      end
      ST_W_MEPC:    state_d = ST_W_MCAUSE;
`ifdef TRAP_MTVAL_EN
      ST_W_MCAUSE:  state_d = ST_W_MTVAL;
      ST_W_MTVAL:   state_d = ST_W_MSTATUS;
`else
      ST_W_MCAUSE:  state_d = ST_W_MSTATUS;
`endif
      ST_W_MSTATUS: state_d = ST_REDIRECT;
      ST_M_STATUS:  state_d = ST_REDIRECT;
      ST_REDIRECT:  state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      is_mret_q <= 1'b0;
      pc_q      <= '0;
      cause_q   <= '0;
`ifdef TRAP_MTVAL_EN
      tval_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      is_mret_q <= is_mret_d;
      pc_q      <= pc_d;
      cause_q   <= cause_d;
`ifdef TRAP_MTVAL_EN
      tval_q    <= tval_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // CSR write port: pass-through in IDLE, sequence writes decoded from state.
  // Reset gating is needed because IDLE pass-through is combinational from
  // the decode inputs.
  // --------------------------------------------------------------------------
  always_comb begin
    csr_we    = 1'b0;
    csr_waddr = '0;
    csr_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        // An accepting cycle suppresses the decode write (e.g. ECALL's own
        // mcause write), since the sequence takes over the port.
        if (!accept) begin
          csr_we    = dec_csr_wb;
          csr_waddr = dec_csr_addr;
          csr_wdata = dec_csr_wdata;
        end
      end
      ST_W_MEPC: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MEPC;
        csr_wdata = {pc_q[31:2], 2'b00};
      end
      ST_W_MCAUSE: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MCAUSE;
        csr_wdata = cause_q;
      end
`ifdef TRAP_MTVAL_EN
      ST_W_MTVAL: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MTVAL;
        csr_wdata = tval_q;
      end
`endif
      ST_W_MSTATUS, ST_M_STATUS: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MSTATUS;
        csr_wdata = mstatus_upd;
      end
      default: begin
        csr_we    = 1'b0;
        csr_waddr = '0;
        csr_wdata = '0;
      end
    endcase
    if (rst) begin
      csr_we    = 1'b0;
      csr_waddr = '0;
      csr_wdata = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Status and redirect. The redirect target is read live in REDIRECT so the
  // mepc/mtvec values reflect every write the sequence has committed.
  // --------------------------------------------------------------------------
  assign busy           = !is_idle;
  assign stall          = !rst & (accept | !is_idle);
  assign redirect_valid = (state_q == ST_REDIRECT);
  assign redirect_pc    = (state_q != ST_REDIRECT) ? RESET_PC :
                          is_mret_q ? mepc : {mtvec[31:2], 2'b00};

endmodule

`default_nettype wire

// File: tb/tb_trap_ctrl.sv
// ============================================================================
// Module  : tb_trap_ctrl
// Purpose : Self-checking bench for trap_ctrl: table of IDLE-cycle vectors
//           plus hand-written trap, MRET, simultaneous-request and
//           reset-abort sequences. Follows TRAP_MTVAL_EN like the design.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trap_ctrl;

  localparam logic [31:0] RPC = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_req, mret_req, dec_csr_wb;
  logic [31:0] trap_cause, trap_pc, trap_tval;
  logic [31:0] dec_csr_addr, dec_csr_wdata;
  logic [31:0] mstatus, mtvec, mepc;
  logic        csr_we, stall, busy, redirect_valid;
  logic [31:0] csr_waddr, csr_wdata, redirect_pc;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  trap_ctrl #(.RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst            (rst),
    .trap_req       (trap_req),
    .trap_cause     (trap_cause),
    .trap_pc        (trap_pc),
    .trap_tval      (trap_tval),
    .mret_req       (mret_req),
    .dec_csr_wb     (dec_csr_wb),
    .dec_csr_addr   (dec_csr_addr),
    .dec_csr_wdata  (dec_csr_wdata),
    .mstatus        (mstatus),
    .mtvec          (mtvec),
    .mepc           (mepc),
    .csr_we         (csr_we),
    .csr_waddr      (csr_waddr),
    .csr_wdata      (csr_wdata),
    .stall          (stall),
    .busy           (busy),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Full output snapshot of one cycle.
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        rv;
    logic [31:0] rpc;
    logic        stall;
    logic        busy;
  } step_t;

  task automatic check_step(input string tag, input step_t s);
    check({tag, ".we"},    {31'd0, csr_we}, {31'd0, s.we});
    if (s.we) begin
      check({tag, ".addr"}, csr_waddr, s.addr);
      check({tag, ".data"}, csr_wdata, s.data);
    end
    check({tag, ".rv"},    {31'd0, redirect_valid}, {31'd0, s.rv});
    check({tag, ".rpc"},   redirect_pc, s.rpc);
    check({tag, ".stall"}, {31'd0, stall}, {31'd0, s.stall});
    check({tag, ".busy"},  {31'd0, busy}, {31'd0, s.busy});
  endtask

  task automatic clear_reqs();
    trap_req   = 1'b0;
    mret_req   = 1'b0;
    dec_csr_wb = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 12) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, ".idle_timeout"}, {31'd0, busy}, 32'd0);
  endtask

  // Trap sequence. With hold_all set, trap/mret/decode-write stay asserted
  // through the sequence to show they are ignored outside IDLE.
  task automatic run_trap(input string tag, input logic [31:0] pc, input logic hold_all);
    step_t seq[$];
    int    stall_cnt;
    @(negedge clk);
    trap_req   = 1'b1;
    trap_cause = 32'd11;
    trap_pc    = pc;
    trap_tval  = 32'h0000_BAD0;
    mstatus    = 32'h0000_0008;
    mtvec      = 32'h0000_0201;
    mepc       = 32'h0000_0777;
    mret_req   = hold_all;
    dec_csr_wb = hold_all;
    dec_csr_addr  = 32'h0000_0342;
    dec_csr_wdata = 32'h0000_00EE;
    #1;
    check_step({tag, ".T0"}, '{1'b0, 32'h0, 32'h0, 1'b0, RPC, 1'b1, 1'b0});
    stall_cnt = 1;
    seq.push_back('{1'b1, 32'h341, {pc[31:2], 2'b00}, 1'b0, RPC, 1'b1, 1'b1});
    seq.push_back('{1'b1, 32'h342, 32'd11, 1'b0, RPC, 1'b1, 1'b1});
`ifdef TRAP_MTVAL_EN
    seq.push_back('{1'b1, 32'h343, 32'h0000_BAD0, 1'b0, RPC, 1'b1, 1'b1});
`endif
    seq.push_back('{1'b1, 32'h300, 32'h0000_1880, 1'b0, RPC, 1'b1, 1'b1});
    seq.push_back('{1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0200, 1'b1, 1'b1});
    seq.push_back('{1'b0, 32'h0, 32'h0, 1'b0, RPC, 1'b0, 1'b0});
    foreach (seq[i]) begin
      @(negedge clk);
      if (!hold_all || seq[i].rv) clear_reqs();
      #1;
      if (stall) stall_cnt++;
      check_step($sformatf("%s.T%0d", tag, i + 1), seq[i]);
    end
`ifdef TRAP_MTVAL_EN
    check({tag, ".stall_cycles"}, stall_cnt, 6);
`else
    check({tag, ".stall_cycles"}, stall_cnt, 5);
`endif
  endtask

  typedef struct {
    logic        trap;
    logic        mret;
    logic        wb;
    logic [31:0] addr;
    logic [31:0] data;
    logic        exp_we;
    logic        chk_ad;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic        exp_stall;
  } vec_t;

  initial begin
    vec_t vecs[6];
    vecs[0] = '{1'b0, 1'b0, 1'b1, 32'h340, 32'h0000_DEAD, 1'b1, 1'b1, 32'h340, 32'h0000_DEAD, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 32'h340, 32'h0000_BEEF, 1'b0, 1'b1, 32'h340, 32'h0000_BEEF, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h305, 32'h8000_0101, 1'b1, 1'b1, 32'h305, 32'h8000_0101, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h300, 32'h1234_5678, 1'b0, 1'b0, 32'h0,   32'h0,         1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 32'h342, 32'h0000_000B, 1'b0, 1'b0, 32'h0,   32'h0,         1'b1};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 32'hFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'hFFF, 32'hFFFF_FFFF, 1'b0};

    // Reset state, with requests and a decode write present on the inputs.
    rst = 1'b1;
    trap_req = 1'b1; mret_req = 1'b1; dec_csr_wb = 1'b1;
    trap_cause = 32'd11; trap_pc = 32'h104; trap_tval = 32'h0;
    dec_csr_addr = 32'h340; dec_csr_wdata = 32'hDEAD;
    mstatus = 32'h8; mtvec = 32'h201; mepc = 32'h108;
    repeat (2) @(negedge clk);
    #1;
    check_step("reset", '{1'b0, 32'h0, 32'h0, 1'b0, RPC, 1'b0, 1'b0});
    check("reset.waddr", csr_waddr, 32'h0);
    check("reset.wdata", csr_wdata, 32'h0);
    @(negedge clk);
    clear_reqs();
    rst = 1'b0;

    // IDLE vectors: pass-through and accept-cycle suppression.
    foreach (vecs[i]) begin
      @(negedge clk);
      trap_req = vecs[i].trap;
      mret_req = vecs[i].mret;
      dec_csr_wb = vecs[i].wb;
      dec_csr_addr = vecs[i].addr;
      dec_csr_wdata = vecs[i].data;
      #1;
      check($sformatf("vec%0d.we", i), {31'd0, csr_we}, {31'd0, vecs[i].exp_we});
      check($sformatf("vec%0d.stall", i), {31'd0, stall}, {31'd0, vecs[i].exp_stall});
      if (vecs[i].chk_ad) begin
        check($sformatf("vec%0d.addr", i), csr_waddr, vecs[i].exp_addr);
        check($sformatf("vec%0d.data", i), csr_wdata, vecs[i].exp_data);
      end
      @(negedge clk);
      clear_reqs();
      #1;
      wait_idle($sformatf("vec%0d", i));
    end

    // ECALL.
    run_trap("ecall", 32'h0000_0104, 1'b0);

    // Simultaneous trap + mret + decode write, held through the sequence;
    // also checks that mepc's low PC bits are cleared.
    run_trap("simul", 32'h0000_010B, 1'b1);

    // MRET.
    @(negedge clk);
    mret_req = 1'b1;
    mstatus  = 32'h0000_1880;
    mepc     = 32'h0000_0108;
    mtvec    = 32'h0000_0201;
    #1;
    check_step("mret.T0", '{1'b0, 32'h0, 32'h0, 1'b0, RPC, 1'b1, 1'b0});
    @(negedge clk);
    clear_reqs();
    #1;
    check_step("mret.T1", '{1'b1, 32'h300, 32'h0000_1888, 1'b0, RPC, 1'b1, 1'b1});
    @(negedge clk);
    #1;
    check_step("mret.T2", '{1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0108, 1'b1, 1'b1});
    @(negedge clk);
    #1;
    check_step("mret.T3", '{1'b0, 32'h0, 32'h0, 1'b0, RPC, 1'b0, 1'b0});

    // Reset asserted while in W_MCAUSE aborts the trap sequence.
    @(negedge clk);
    trap_req = 1'b1; trap_cause = 32'd11; trap_pc = 32'h104;
    mstatus = 32'h8; mtvec = 32'h201;
    @(negedge clk);
    clear_reqs();
    @(negedge clk);
    #1;
    check("abort.in_mcause", csr_waddr, 32'h342);
    rst = 1'b1;
    #1;
    check_step("abort.rst", '{1'b0, 32'h0, 32'h0, 1'b0, RPC, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check_step($sformatf("abort.after%0d", k), '{1'b0, 32'h0, 32'h0, 1'b0, RPC, 1'b0, 1'b0});
    end

    // Pass-through still works after the aborted sequence.
    @(negedge clk);
    dec_csr_wb = 1'b1; dec_csr_addr = 32'h340; dec_csr_wdata = 32'hDEAD;
    #1;
    check_step("post.pass", '{1'b1, 32'h340, 32'h0000_DEAD, 1'b0, RPC, 1'b0, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
